// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch stage: default widths, PC increment and
// the packed {pc, instr} entry layout used by default-width consumers.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int INSTR_W_DEF = 32;
  localparam int PC_STEP     = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bus between the fetch queue and its neighbours: the ProgramCounter and
// instruction memory on the upstream side, decode on the downstream side.
// The slave modport is the fetch queue itself; master is its environment.
interface fetch_queue_if #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
  parameter int INSTR_W = fetch_pkg::INSTR_W_DEF
);

  logic               fetch_en;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instruction;
  logic               pc_write;
  logic [ADDR_W-1:0]  next_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;

  modport slave (
    input  fetch_en, pc, instruction, redirect_valid, redirect_pc, out_ready,
    output pc_write, next_pc, out_valid, out_pc, out_instr
  );

  modport master (
    output fetch_en, pc, instruction, redirect_valid, redirect_pc, out_ready,
    input  pc_write, next_pc, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic circular-buffer FIFO with push, pop and a synchronous flush.
// Flush wins over push and pop. The head reads as zero while empty.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (push_i) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (pop_i)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents only matter while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wrPtr_q] <= wdata_i;
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = empty_o ? '0 : mem_q[rdPtr_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: captures {pc, instruction} into a prefetch FIFO, advances the
// ProgramCounter only when an entry is accepted, and flushes on redirect.
// Optional performance counters are enabled with FETCH_QUEUE_PERF_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  fetch_queue_if.slave bus
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic   push, pop, full, empty;
  entry_t wrEntry, headEntry;
  logic [1:0] unusedRedirectLsb;

  // Accept/retire decisions; pop depends only on registered occupancy and out_ready.
  always_comb begin
    pop  = !empty && bus.out_ready;
    push = bus.fetch_en && !bus.redirect_valid && (!full || pop);
    wrEntry.pc    = bus.pc;
    wrEntry.instr = bus.instruction;
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ADDR_W + INSTR_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(bus.redirect_valid),
    .wdata_i(wrEntry),
    .full_o (full),
    .empty_o(empty),
    .head_o (headEntry)
  );

  // Redirect targets are word-aligned, so the low PC bits are dropped.
  assign unusedRedirectLsb = bus.redirect_pc[1:0];

  assign bus.pc_write  = !reset && (push || bus.redirect_valid);
  assign bus.next_pc   = bus.redirect_valid ? {bus.redirect_pc[ADDR_W-1:2], 2'b00}
                                            : bus.pc + ADDR_W'(PC_STEP);
  assign bus.out_valid = !empty;
  assign bus.out_pc    = headEntry.pc;
  assign bus.out_instr = headEntry.instr;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stallCycles_q;
  logic [15:0] flushCount_q;

  // Saturating counters for fetch stalls and redirect flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      if (bus.fetch_en && !push && !bus.redirect_valid && (stallCycles_q != '1))
        stallCycles_q <= stallCycles_q + 32'd1;
      if (bus.redirect_valid && (flushCount_q != '1))
        flushCount_q <= flushCount_q + 16'd1;
    end
  end

  assign stall_cycles = stallCycles_q;
  assign flush_count  = flushCount_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue. The bench plays ProgramCounter and
// instruction memory, keeps a queue-based model of the fetch stage, and
// compares every DUT output against that model each cycle, with literal
// spot checks along the way.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  fetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stallCycles;
  logic [15:0] flushCount;
`endif

  fetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .INSTR_W(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .stall_cycles(stallCycles),
    .flush_count (flushCount)
`endif
  );

  fetch_entry_t modelQ[$];
  logic [31:0]  pcReg = 32'd0;
  logic         expPush, expPop, expPcWrite;
  logic [31:0]  expNextPc;
  int           checks = 0;
  int           failures = 0;

  // Instruction memory contents: a simple reversible pattern of the address.
  function automatic logic [31:0] instrOf(input logic [31:0] p);
    return p ^ 32'hA000_0013;
  endfunction

  // Single comparison with failure reporting.
  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Derive expected outputs from the model queue and the current inputs.
  task automatic checkOutput();
    logic [31:0] expPc, expInstr;
    logic        expValid;
    expValid   = (modelQ.size() != 0);
    expPop     = !reset && expValid && bus.out_ready;
    expPush    = !reset && bus.fetch_en && !bus.redirect_valid &&
                 ((modelQ.size() < DEPTH) || expPop);
    expPcWrite = !reset && (expPush || bus.redirect_valid);
    expNextPc  = bus.redirect_valid ? (bus.redirect_pc & 32'hFFFF_FFFC) : bus.pc + 32'd4;
    expPc      = expValid ? modelQ[0].pc : 32'd0;
    expInstr   = expValid ? modelQ[0].instr : 32'd0;
    checkVal("out_valid", {31'd0, bus.out_valid}, {31'd0, expValid});
    checkVal("out_pc", bus.out_pc, expPc);
    checkVal("out_instr", bus.out_instr, expInstr);
    checkVal("pc_write", {31'd0, bus.pc_write}, {31'd0, expPcWrite});
    checkVal("next_pc", bus.next_pc, expNextPc);
  endtask

  // Drive one cycle of inputs after the falling edge, then check outputs.
  task automatic applyStimulus(input logic rst, input logic fe, input logic rdy,
                               input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset              = rst;
    bus.fetch_en       = fe;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.pc             = pcReg;
    bus.instruction    = instrOf(pcReg);
    #2;
    checkOutput();
  endtask

  // Advance the model and the ProgramCounter stand-in across the rising edge.
  task automatic tick();
    fetch_entry_t e;
    @(posedge clk);
    if (reset) begin
      modelQ.delete();
      pcReg = 32'd0;
    end else begin
      if (bus.redirect_valid) begin
        modelQ.delete();
      end else begin
        if (expPop) void'(modelQ.pop_front());
        if (expPush) begin
          e.pc    = bus.pc;
          e.instr = bus.instruction;
          modelQ.push_back(e);
        end
      end
      if (expPcWrite) pcReg = expNextPc;
    end
  endtask

  // Main directed sequence.
  initial begin
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.pc             = 32'd0;
    bus.instruction    = 32'd0;

    // Hold reset for two cycles and check the idle state.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      checkVal("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkVal("rst_pc_write", {31'd0, bus.pc_write}, 32'd0);
      tick();
    end

    // Streaming fetch from pc 0 with decode always ready.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkVal("stream_pc_write", {31'd0, bus.pc_write}, 32'd1);
      if (i == 0) checkVal("stream_first_valid", {31'd0, bus.out_valid}, 32'd0);
      if (i >= 1 && i <= 4) checkVal("stream_out_pc", bus.out_pc, 32'(4 * (i - 1)));
      if (i == 4) checkVal("stream_out_instr", bus.out_instr, 32'hA000_001F);
      tick();
    end

    // Redirect to 0 while popping, leaving an empty queue.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'd0);
    checkVal("redir0_next_pc", bus.next_pc, 32'd0);
    tick();

    // Fill from empty with decode stalled: four pushes, then the PC holds.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      checkVal("full_pc_write", {31'd0, bus.pc_write}, 32'd0);
      checkVal("full_next_pc", bus.next_pc, 32'h14);
      checkVal("full_out_pc", bus.out_pc, 32'd0);
      tick();
    end

    // Full queue with one ready cycle: simultaneous push and pop.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("pushpop_pc_write", {31'd0, bus.pc_write}, 32'd1);
    checkVal("pushpop_next_pc", bus.next_pc, 32'h14);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkVal("after_pushpop_out_pc", bus.out_pc, 32'h4);
    checkVal("after_pushpop_pc_write", {31'd0, bus.pc_write}, 32'd0);
    tick();

    // Three entries queued, redirect to a misaligned target.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h43);
    checkVal("redir_next_pc", bus.next_pc, 32'h40);
    checkVal("redir_pc_write", {31'd0, bus.pc_write}, 32'd1);
    checkVal("redir_out_pc", bus.out_pc, 32'h8);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("post_redir_valid", {31'd0, bus.out_valid}, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("target_out_pc", bus.out_pc, 32'h40);
    checkVal("target_out_instr", bus.out_instr, 32'hA000_0053);
    tick();

    // PC wrap-around at the top of the address space.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    checkVal("top_next_pc", bus.next_pc, 32'hFFFF_FFFC);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("wrap_next_pc", bus.next_pc, 32'd0);
    checkVal("wrap_pc_write", {31'd0, bus.pc_write}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    tick();

    // Queue two entries, then assert reset between clock edges.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    checkVal("pre_reset_out_pc", bus.out_pc, 32'h100);
    #1;
    reset = 1'b1;
    #1;
    checkVal("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    checkVal("async_rst_pc_write", {31'd0, bus.pc_write}, 32'd0);
    modelQ.delete();
    pcReg = 32'd0;
    checkOutput();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    tick();

    // Restart after reset release from the ProgramCounter value.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("restart_pc_write", {31'd0, bus.pc_write}, 32'd1);
    checkVal("restart_next_pc", bus.next_pc, 32'h4);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    checkVal("restart_out_pc", bus.out_pc, 32'd0);
    tick();

    // Mixed enable/ready pattern to exercise partial occupancy.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, (i % 3) != 2, (i % 4) == 1 || (i % 4) == 2, 1'b0, 32'd0);
      tick();
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
